// File: rtl/parallel_to_serial_pkg.sv
// -----------------------------------------------------------------------------
// parallel_to_serial_pkg
// Shared definitions for the parallel-to-serial converter.
// Holds only width-independent items so every instance width can share it.
// -----------------------------------------------------------------------------
package parallel_to_serial_pkg;

    // Serializer FSM state.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } p2s_state_t;

endpackage : parallel_to_serial_pkg

// File: rtl/parallel_to_serial_hold_buffer.sv
// -----------------------------------------------------------------------------
// p2s_hold_buffer
// One-word pending register with a full flag. Catches a word offered while
// the shift register is still busy, and hands it over when the last bit of
// the current word is accepted.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-low reset
//   load     in   capture data_in, set full
//   take     in   consumer has taken the word, clear full
//   data_in  in   [width-1:0] word to hold
//   data     out  [width-1:0] held word (0 when empty)
//   full     out  a word is held
// -----------------------------------------------------------------------------
module p2s_hold_buffer #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             take,
    input  logic [width-1:0] data_in,
    output logic [width-1:0] data,
    output logic             full
);

    // load and take are never asserted together by the top: load needs the
    // buffer empty, take needs it full. load is given priority regardless.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= data_in;
            full <= 1'b1;
        end else if (take) begin
            data <= '0;
            full <= 1'b0;
        end
    end

endmodule : p2s_hold_buffer

// File: rtl/parallel_to_serial.sv
// -----------------------------------------------------------------------------
// parallel_to_serial
// Serializes width-bit words LSB first with valid/ready handshakes on both
// sides. A shift register carries the word in flight; a one-word hold buffer
// lets upstream deliver the next word early so consecutive words stream
// without a bubble.
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-low reset
//   parallel_valid  in   upstream word present
//   parallel_data   in   [width-1:0] word to serialize
//   parallel_ready  out  a word can be accepted this cycle
//   serial_valid    out  serial_data carries a valid bit
//   serial_data     out  current bit, LSB first
//   serial_ready    in   downstream accepts the current bit
//   serial_last     out  current bit is bit width-1 of its word
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | shift register empty, serial_valid low
// SHIFT | word in flight, bit bit_cnt presented on serial_data
// -----------------------------------------------------------------------------
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    input  logic [width-1:0] parallel_data,
    output logic             parallel_ready,
    output logic             serial_valid,
    output logic             serial_data,
    input  logic             serial_ready,
    output logic             serial_last
);

    localparam int                CNT_W    = $clog2(width);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

    p2s_state_t       state;
    logic [width-1:0] shift_reg;
    logic [CNT_W-1:0] bit_cnt;

    logic [width-1:0] pend_data;
    logic             pend_full;

    logic             accept;
    logic             bit_fire;
    logic             last_fire;
    logic             pend_load;
    logic             pend_take;

    // Ready depends on the pending flag only, so there is no combinational
    // path from either handshake input to parallel_ready.
    assign parallel_ready = ~pend_full;
    assign accept         = parallel_valid & ~pend_full;

    assign bit_fire  = (state == SHIFT) & serial_ready;
    assign last_fire = bit_fire & (bit_cnt == LAST_BIT);

    // A word arriving while busy parks in the hold buffer, except on the
    // edge the last bit leaves with nothing pending: then it goes straight
    // into the shift register instead.
    assign pend_load = accept & (state == SHIFT) & ~last_fire;
    assign pend_take = last_fire & pend_full;

    p2s_hold_buffer #(
        .width (width)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .load    (pend_load),
        .take    (pend_take),
        .data_in (parallel_data),
        .data    (pend_data),
        .full    (pend_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= parallel_data;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (last_fire) begin
                        bit_cnt <= '0;
                        // Pending word has priority; accept is impossible
                        // when it is present since parallel_ready is low.
                        if (pend_full) begin
                            shift_reg <= pend_data;
                        end else if (accept) begin
                            shift_reg <= parallel_data;
                        end else begin
                            shift_reg <= '0;
                            state     <= IDLE;
                        end
                    end else if (bit_fire) begin
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    shift_reg <= '0;
                    bit_cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs are decodes of registers only; data and last are forced to
    // zero whenever no bit is valid.
    assign serial_valid = (state == SHIFT);
    assign serial_data  = serial_valid & shift_reg[0];
    assign serial_last  = serial_valid & (bit_cnt == LAST_BIT);

endmodule : parallel_to_serial

// File: tb/tb_parallel_to_serial.sv
module tb_parallel_to_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         parallel_valid;
    logic [W-1:0] parallel_data;
    logic         parallel_ready;
    logic         serial_valid;
    logic         serial_data;
    logic         serial_ready;
    logic         serial_last;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: every accepted word must come out, in order, as W
    // consecutive accepted bits LSB first, with last on the W-th bit only.
    logic [W-1:0] sent_q[$];
    int           n_tx   = 0;
    int           n_rx   = 0;
    int           rx_idx = 0;
    logic [W-1:0] rx_word = '0;

    parallel_to_serial #(.width(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .parallel_valid (parallel_valid),
        .parallel_data  (parallel_data),
        .parallel_ready (parallel_ready),
        .serial_valid   (serial_valid),
        .serial_data    (serial_data),
        .serial_ready   (serial_ready),
        .serial_last    (serial_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks the W bits of word w, one per cycle, with serial_ready held high.
    task automatic expect_word(input string tag, input logic [W-1:0] w);
        logic [W-1:0] s;
        s = w;
        for (int i = 0; i < W; i++) begin
            check({tag, "_valid"}, 32'(serial_valid), 32'd1);
            check({tag, "_data"},  32'(serial_data),  32'(s[0]));
            check({tag, "_last"},  32'(serial_last),  32'(i == W - 1));
            s = s >> 1;
            tick();
        end
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while ((serial_valid || sent_q.size() != 0) && cyc < 400) begin
            tick();
            cyc++;
        end
        check({tag, "_drained"}, 32'(serial_valid), 32'd0);
        check({tag, "_queue"},   32'(sent_q.size()), 32'd0);
    endtask

    // Monitor: samples handshakes on the clock edge (pre-update values).
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                n_tx    = n_tx - sent_q.size();
                sent_q.delete();
                rx_idx  = 0;
                rx_word = '0;
            end else begin
                if (parallel_valid && parallel_ready) begin
                    sent_q.push_back(parallel_data);
                    n_tx++;
                end
                if (!serial_valid) begin
                    check("idle_data", 32'(serial_data), 32'd0);
                    check("idle_last", 32'(serial_last), 32'd0);
                end else if (serial_ready) begin
                    check("mon_last", 32'(serial_last), 32'(rx_idx == W - 1));
                    rx_word = {serial_data, rx_word[W-1:1]};
                    rx_idx++;
                    if (rx_idx == W) begin
                        logic [W-1:0] exp_w;
                        exp_w = (sent_q.size() != 0) ? sent_q.pop_front() : ~rx_word;
                        check("mon_word", 32'(rx_word), 32'(exp_w));
                        n_rx++;
                        rx_idx = 0;
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] words [3];
        logic [W-1:0] got;
        logic         rdy, prev_sd, prev_sl, prev_stall;
        int           k, cyc, nbits, blocked, nval, first, last, tx0, rx0, acc;

        rst            = 1'b0;
        parallel_valid = 1'b0;
        parallel_data  = '0;
        serial_ready   = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", 32'(parallel_ready), 32'd1);
        check("rst_valid", 32'(serial_valid),   32'd0);
        check("rst_data",  32'(serial_data),    32'd0);
        check("rst_last",  32'(serial_last),    32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_ready", 32'(parallel_ready), 32'd1);
        check("post_rst_valid", 32'(serial_valid),   32'd0);

        // Single word 0xA5, latency one cycle
        serial_ready   = 1'b1;
        parallel_valid = 1'b1;
        parallel_data  = 8'hA5;
        tick();
        parallel_valid = 1'b0;
        expect_word("a5", 8'hA5);
        check("a5_end_valid", 32'(serial_valid), 32'd0);

        // Back-to-back words stream without a bubble
        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
        k = 0; blocked = 0; nval = 0; first = -1; last = -1;
        for (int c = 0; c < 40; c++) begin
            if (serial_valid) begin
                nval++;
                if (first < 0) first = c;
                last = c;
            end
            rdy = parallel_ready;
            if (k < 3) begin
                parallel_valid = 1'b1;
                parallel_data  = words[k];
                if (!rdy) blocked++;
            end else begin
                parallel_valid = 1'b0;
            end
            tick();
            if (rdy && k < 3) k++;
        end
        parallel_valid = 1'b0;
        check("b2b_accepted",   32'(k),                32'd3);
        check("b2b_bits",       32'(nval),             32'd24);
        check("b2b_contiguous", 32'(last - first + 1), 32'd24);
        check("b2b_ready_low",  32'(blocked != 0),     32'd1);

        // 0x3C with stalls: serial_ready 1,0,0,1,...
        parallel_valid = 1'b1;
        parallel_data  = 8'h3C;
        tick();
        parallel_valid = 1'b0;
        got = '0; nbits = 0; cyc = 0; prev_stall = 1'b0; prev_sd = 1'b0; prev_sl = 1'b0;
        while (nbits < W && cyc < 40) begin
            serial_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (prev_stall) begin
                check("stall_hold_data", 32'(serial_data), 32'(prev_sd));
                check("stall_hold_last", 32'(serial_last), 32'(prev_sl));
            end
            if (serial_valid && serial_ready) begin
                got = {serial_data, got[W-1:1]};
                nbits++;
            end
            prev_sd    = serial_data;
            prev_sl    = serial_last;
            prev_stall = !serial_ready;
            tick();
            cyc++;
        end
        serial_ready = 1'b1;
        check("stall_nbits", 32'(nbits), 32'(W));
        check("stall_seq",   32'(got),   32'h3C);
        check("stall_idle",  32'(serial_valid), 32'd0);

        // Pending word with long downstream stall holds off a third word
        tx0 = n_tx;
        serial_ready   = 1'b0;
        parallel_valid = 1'b1;
        parallel_data  = 8'h11;
        tick();
        parallel_data  = 8'h22;
        tick();
        parallel_data  = 8'h33;
        blocked = 0;
        for (int c = 0; c < 20; c++) begin
            if (!parallel_ready) blocked++;
            tick();
        end
        check("hold_ready_low", 32'(blocked),    32'd20);
        check("hold_tx_count",  32'(n_tx - tx0), 32'd2);
        serial_ready = 1'b1;
        cyc = 0;
        rdy = 1'b0;
        while (!rdy && cyc < 50) begin
            rdy = parallel_ready;
            tick();
            cyc++;
        end
        parallel_valid = 1'b0;
        check("hold_third_accepted", 32'(n_tx - tx0), 32'd3);
        drain("hold");

        // Reset mid-word with a pending word
        parallel_valid = 1'b1;
        parallel_data  = 8'hF0;
        tick();
        parallel_data  = 8'h0F;
        tick();
        parallel_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_pending", 32'(parallel_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 32'(parallel_ready), 32'd1);
        check("mid_rst_valid", 32'(serial_valid),   32'd0);
        check("mid_rst_data",  32'(serial_data),    32'd0);
        check("mid_rst_last",  32'(serial_last),    32'd0);
        tick();
        rst = 1'b1;
        check("rel_rst_valid", 32'(serial_valid), 32'd0);
        parallel_valid = 1'b1;
        parallel_data  = 8'h55;
        tick();
        parallel_valid = 1'b0;
        expect_word("w55", 8'h55);
        drain("w55");

        // 100 random words, serial_ready high
        rx0 = n_rx; acc = 0; cyc = 0;
        while (acc < 100 && cyc < 3000) begin
            parallel_valid = ($urandom_range(0, 3) != 0);
            parallel_data  = W'($urandom);
            rdy = parallel_ready;
            tick();
            if (parallel_valid && rdy) acc++;
            cyc++;
        end
        parallel_valid = 1'b0;
        check("rand_accepted", 32'(acc), 32'd100);
        drain("rand");
        check("rand_received", 32'(n_rx - rx0), 32'd100);

        // 50 random words with random downstream stalls
        rx0 = n_rx; acc = 0; cyc = 0;
        while (acc < 50 && cyc < 4000) begin
            parallel_valid = ($urandom_range(0, 1) != 0);
            parallel_data  = W'($urandom);
            serial_ready   = ($urandom_range(0, 2) != 0);
            rdy = parallel_ready;
            tick();
            if (parallel_valid && rdy) acc++;
            cyc++;
        end
        parallel_valid = 1'b0;
        serial_ready   = 1'b1;
        check("rstall_accepted", 32'(acc), 32'd50);
        drain("rstall");
        check("rstall_received", 32'(n_rx - rx0), 32'd50);
        check("total_words",     32'(n_rx),        32'(n_tx));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_parallel_to_serial

// File: doc/parallel_to_serial.md
PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 Parameter: width, default 8, number of bits per parallel word; SHALL be >= 2.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-low reset; one clock, no other clock domains.
REQ-004 Port: parallel_valid  input  1  upstream word present on parallel_data.
REQ-005 Port: parallel_data  input  width  word to serialize.
REQ-006 Port: parallel_ready  output  1  block can accept a word this cycle.
REQ-007 Port: serial_valid  output  1  serial_data carries a valid bit.
REQ-008 Port: serial_data  output  1  current bit, LSB first.
REQ-009 Port: serial_ready  input  1  downstream accepts the current bit this cycle.
REQ-010 Port: serial_last  output  1  current bit is bit width-1 of its word.

Function
REQ-011 A word SHALL be accepted on a rising edge where parallel_valid and parallel_ready are both high; no other input handshake exists.
REQ-012 Storage SHALL be one shift register plus one pending-word register; parallel_ready SHALL equal NOT pending-full, derived from registers only (no combinational path from serial_ready or parallel_valid).
REQ-013 FSM states: IDLE (shift register empty) and SHIFT (word in flight); IDLE->SHIFT on load; SHIFT->IDLE when the last bit is accepted and no word is pending or arriving.
REQ-014 A word accepted in IDLE SHALL load directly into the shift register; serial_valid SHALL be high with bit 0 in the next cycle (latency 1).
REQ-015 A word accepted in SHIFT SHALL go to the pending register.
REQ-016 A bit SHALL advance only on an edge where serial_valid and serial_ready are both high; while serial_ready is low, serial_data and serial_last SHALL hold.
REQ-017 Bits SHALL be emitted in order bit 0 .. bit width-1; serial_last SHALL be high exactly with bit width-1.
REQ-018 On the edge the last bit is accepted: pending word present -> load it (pending clears); else word accepted same edge -> load it directly; either way bit 0 appears next cycle with no bubble.
REQ-019 A word accepted on the same edge a pending word moves into the shift register is impossible (parallel_ready low); no word SHALL be lost or duplicated under any handshake pattern.
REQ-020 When serial_valid is low, serial_data and serial_last SHALL be 0.
REQ-021 Bit counter SHALL be $clog2(width) bits and wrap to 0 after bit width-1.

Reset
REQ-022 Asserting rst SHALL immediately clear state to IDLE, counter to 0, pending-full to 0, shift and pending registers to 0.
REQ-023 During and after reset: parallel_ready=1, serial_valid=0, serial_data=0, serial_last=0.
REQ-024 Reset mid-word SHALL discard the in-flight and pending words; first post-reset word starts at bit 0.

Structure
REQ-025 Package parallel_to_serial_pkg SHALL hold the FSM state enum (IDLE, SHIFT) and no width-dependent types.
REQ-026 The pending register with its full flag SHALL be a sub-module p2s_hold_buffer (parameter width; load, take, data, full); shift logic and FSM stay in the top.

Verification
REQ-027 Reset, width=8, 0xA5 offered with serial_ready=1 -> serial bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one cycle after acceptance, serial_last on the 8th only.
REQ-028 Back-to-back 0x01, 0x80, 0xFF with serial_ready=1 -> 24 contiguous valid bits, no bubble; parallel_ready low while pending full.
REQ-029 0x3C in flight, serial_ready toggled 1,0,0,1,... -> serial_data holds during stalls; bit sequence still 0,0,1,1,1,1,0,0.
REQ-030 Pending word present and serial_ready=0 for 20 cycles -> parallel_ready stays 0, third word held off upstream, no data lost.
REQ-031 rst asserted after 3 bits of 0xF0 with a pending 0x0F -> outputs zero immediately, parallel_ready=1; next word 0x55 emits from bit 0.
REQ-032 Loopback into serial_to_parallel (serial_ready=1), 100 random words -> every recovered parallel_data matches the sent word in order.
